lsu: RTL and testbench
======================

# lsu

Load/store unit for the single-issue RV32 core: accepts one memory request from the execute stage, performs it over a valid/ready data-memory bus, and returns the aligned, sign/zero-extended load data to writeback. Its load result drives `mem_rd_data_in` of writeback; stores complete with a zero-data response. One transaction is outstanding at a time. A multi-cycle FSM tolerates arbitrary memory wait states.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width (`REG_WIDTH`)

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  execute stage offers a request
- `req_ready`  out  1  LSU can accept a request
- `req_wen`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU; SB/SH/SW)
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  DATA_W  store data from rs2
- `resp_valid`  out  1  result available
- `resp_ready`  in  1  writeback accepts result
- `resp_rdata`  out  DATA_W  extended load data; 0 for stores and errors
- `resp_err`  out  1  access fault or illegal funct3
- `mem_valid`  out  1  bus request
- `mem_ready`  in  1  bus accepts request
- `mem_wen`  out  1  bus write
- `mem_addr`  out  ADDR_W  word-aligned address, `{req_addr[ADDR_W-1:2],2'b00}`
- `mem_wdata`  out  DATA_W  lane-replicated store data
- `mem_wmask`  out  4  byte strobes
- `mem_rvalid`  in  1  completion for reads and writes
- `mem_rdata`  in  DATA_W  read word
- `mem_err`  in  1  bus fault, sampled with `mem_rvalid`

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`, latch wen/funct3/addr/wdata.
  - Legal request goes to REQ.
  - Illegal funct3 (load 011/110/111, store 011 or 1xx) goes directly to RESP with err=1. No bus activity.
- REQ: `mem_valid`=1 with the latched fields held stable.
  - On `mem_ready`, go to WAIT.
  - If `mem_ready` and `mem_rvalid` are both high in the same cycle, go directly to RESP.
- WAIT: on `mem_rvalid`, capture rdata/err and go to RESP. `mem_rvalid` in any other state is ignored.
- RESP: `resp_valid`=1. `resp_rdata`/`resp_err` are held stable until `resp_ready`, then go to IDLE.
- Load extraction: shift the word right by 8*addr[1:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
  - LH uses addr[1] only. LW ignores addr[1:0].
- Store encoding:
  - SB: wdata `{4{b}}`, mask `4'b0001<<addr[1:0]`.
  - SH: wdata `{2{h}}`, mask `4'b0011<<{addr[1],1'b0}`.
  - SW: full word, mask `4'b1111`.
- `mem_err`=1 gives `resp_err`=1 and `resp_rdata`=0.

## Timing
- While `rst` is sampled high, all outputs are 0, including `req_ready`.
- On the first cycle after reset, state is IDLE, `req_ready`=1, and all other outputs are 0.
- `rst` mid-operation: the next edge returns to IDLE and drops `mem_valid`/`resp_valid`. The memory is reset by the same `rst`.
- Minimum latency, accept to `resp_valid`: 2 cycles (accept in cycle 0, REQ in cycle 1 with ready+rvalid, RESP in cycle 2). An illegal or misaligned request takes 1 cycle.
- Back-to-back throughput: one request per 3 cycles minimum. No request is accepted in REQ, WAIT or RESP.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, go from IDLE to RESP with `resp_err`=1 and `resp_rdata`=0.
  - No bus transaction is issued.
- `LSU_MISALIGN_TRAP_EN` undefined: misaligned low bits are silently truncated to the access size as described under Operation, and there is no error.

## Structure
- `macro.v` holds: LSU state encodings, funct3 codes (`LSU_F3_B/H/W/BU/HU`), and mask constants.
- One combinational sub-module, `lsu_align`, performs load extraction/extension and store replication/mask generation. The FSM and registers stay in `lsu`.

## Test plan
- LB at 0x1003, mem_rdata 0x80_00_00_00 → resp_rdata 0xFFFFFF80, err 0. LBU at the same address → 0x00000080.
- SH at 0x2002 with wdata 0x0000BEEF → mem_addr 0x2000, mem_wdata 0xBEEFBEEF, mem_wmask 4'b1100; then resp_rdata 0.
- LW at 0x3000 with `mem_ready` delayed 3 cycles and `mem_rvalid` 2 cycles later → fields held stable throughout; exactly one response.
- `resp_ready` held low for 4 cycles during RESP → `resp_valid`/`resp_rdata` stable and `req_ready`=0. A 2-cycle turnaround then follows.
- Load funct3=011 → resp_err=1 after 1 cycle, `mem_valid` never asserted. With the macro defined, LW at 0x4001 behaves the same; with it undefined, it reads word 0x4000.
- `rst` asserted during WAIT → next cycle IDLE, `mem_valid`=0, `resp_valid`=0. A subsequent LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: LSU FSM state encoding, RV32 load/store funct3 codes, byte-mask constants
// and request-decode helpers shared by lsu and lsu_align.
package lsu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_t;

    localparam logic [2:0] LSU_F3_B  = 3'b000;
    localparam logic [2:0] LSU_F3_H  = 3'b001;
    localparam logic [2:0] LSU_F3_W  = 3'b010;
    localparam logic [2:0] LSU_F3_BU = 3'b100;
    localparam logic [2:0] LSU_F3_HU = 3'b101;

    localparam logic [3:0] LSU_MASK_B = 4'b0001;
    localparam logic [3:0] LSU_MASK_H = 4'b0011;
    localparam logic [3:0] LSU_MASK_W = 4'b1111;

    // Stores have no unsigned variants, so any funct3[2] is illegal for them.
    function automatic logic illegal_f3(input logic wen, input logic [2:0] f3);
        return wen ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        return f3[1:0] == 2'b01 ? off[0] : f3[1:0] == 2'b10 ? |off : 1'b0;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational load extraction/extension and store lane replication/mask generation.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] st_data,
    output logic [3:0]        st_mask
);

    logic [1:0]        sh;
    logic [DATA_W-1:0] w;

    always_comb begin
        sh = funct3[1:0] == LSU_F3_B[1:0] ? off : funct3[1:0] == LSU_F3_H[1:0] ? {off[1], 1'b0} : 2'b00;
        w = rdata >> {sh, 3'b000};
        ld_data = funct3 == LSU_F3_B  ? {{(DATA_W-8){w[7]}}, w[7:0]} :
                  funct3 == LSU_F3_H  ? {{(DATA_W-16){w[15]}}, w[15:0]} :
                  funct3 == LSU_F3_BU ? {{(DATA_W-8){1'b0}}, w[7:0]} :
                  funct3 == LSU_F3_HU ? {{(DATA_W-16){1'b0}}, w[15:0]} : rdata;
        st_data = funct3[1:0] == LSU_F3_B[1:0] ? {(DATA_W/8){wdata[7:0]}} :
                  funct3[1:0] == LSU_F3_H[1:0] ? {(DATA_W/16){wdata[15:0]}} : wdata;
        st_mask = funct3[1:0] == LSU_F3_W[1:0] ? LSU_MASK_W :
                  funct3[1:0] == LSU_F3_H[1:0] ? LSU_MASK_H << {off[1], 1'b0} : LSU_MASK_B << off;
    end

endmodule

// File: rtl/lsu.sv
// lsu: RV32 load/store unit with one outstanding valid/ready data-memory transaction.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of truncating them.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    lsu_state_t        state, state_n;
    logic              wen_q, err_q, bad, done;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q, ld_data, st_data;
    logic [3:0]        st_mask;

`ifdef LSU_MISALIGN_TRAP_EN
    assign bad = illegal_f3(req_wen, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
    assign bad = illegal_f3(req_wen, req_funct3);
`endif

    // A completion in REQ only counts when the request is accepted in the same cycle.
    assign done = (state == S_REQ && mem_ready && mem_rvalid) || (state == S_WAIT && mem_rvalid);

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3 (f3_q),
        .off    (addr_q[1:0]),
        .wdata  (wdata_q),
        .rdata  (mem_rdata),
        .ld_data(ld_data),
        .st_data(st_data),
        .st_mask(st_mask)
    );

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = req_valid ? (bad ? S_RESP : S_REQ) : S_IDLE;
            S_REQ:   state_n = mem_ready ? (mem_rvalid ? S_RESP : S_WAIT) : S_REQ;
            S_WAIT:  state_n = mem_rvalid ? S_RESP : S_WAIT;
            S_RESP:  state_n = resp_ready ? S_IDLE : S_RESP;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_IDLE && req_valid) begin
                wen_q   <= req_wen;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= '0;
                err_q   <= bad;
            end
            if (done) begin
                rdata_q <= (mem_err || wen_q) ? '0 : ld_data;
                err_q   <= mem_err;
            end
        end
    end

    // Outputs are forced low while rst is high, whatever state the FSM was left in.
    assign req_ready  = !rst && state == S_IDLE;
    assign mem_valid  = !rst && state == S_REQ;
    assign mem_wen    = mem_valid && wen_q;
    assign mem_addr   = mem_valid ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata  = mem_wen ? st_data : '0;
    assign mem_wmask  = mem_wen ? st_mask : 4'b0000;
    assign resp_valid = !rst && state == S_RESP;
    assign resp_rdata = resp_valid ? rdata_q : '0;
    assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed and randomized checks of lsu against a byte-level behavioural model and memory.
module tb_lsu;

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 1'b0, req_wen = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, mem_valid, mem_wen;
    logic [31:0] resp_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0, mem_err = 1'b0;
    logic [31:0] mem_rdata = '0;

    int errors = 0, checks = 0;
    logic [31:0] mem [int unsigned];

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected result from byte-level access semantics: size, truncated offset, sign rules.
    function automatic void model(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word, input logic merr,
                                  output logic bad, output logic [31:0] rd, output logic [31:0] wd,
                                  output logic [3:0] m);
        int size, off, eff;
        longint v;
        size = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        off = int'(addr % 4);
        bad = wen ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
`ifdef LSU_MISALIGN_TRAP_EN
        if (off % size != 0) bad = 1'b1;
`endif
        eff = off - off % size;
        v = 0;
        for (int k = 0; k < size; k++) v += longint'((word >> (8 * (eff + k))) & 32'hFF) << (8 * k);
        if (!f3[2] && size < 4 && v >= (longint'(1) << (8 * size - 1))) v -= longint'(1) << (8 * size);
        rd = (bad || merr || wen) ? 32'h0 : v[31:0];
        wd = '0;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            wd[8*k +: 8] = wdata[8*(k % size) +: 8];
            m[k] = (k >= eff && k < eff + size);
        end
    endfunction

    task automatic txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input int rdly, input int vdly, input int pdly, input logic merr);
        logic bad;
        logic [31:0] waddr, word, exp_rd, exp_wd;
        logic [3:0] exp_m;
        waddr = addr & 32'hFFFF_FFFC;
        if (!mem.exists(waddr)) mem[waddr] = $urandom;
        word = mem[waddr];
        model(wen, f3, addr, wdata, word, merr, bad, exp_rd, exp_wd, exp_m);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        tick();
        req_valid = 1'b0; req_wen = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        if (!bad) begin
            for (int i = 0; i <= rdly; i++) begin
                chk("mem_valid_req", mem_valid, 1);
                chk("req_ready_req", req_ready, 0);
                chk("resp_valid_req", resp_valid, 0);
                chk("mem_wen", mem_wen, wen);
                chk("mem_addr", mem_addr, waddr);
                if (wen) begin
                    chk("mem_wdata", mem_wdata, exp_wd);
                    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, exp_m});
                end
                if (i == rdly) begin
                    mem_ready = 1'b1;
                    if (vdly == 0) begin mem_rvalid = 1'b1; mem_rdata = word; mem_err = merr; end
                end
                tick();
                mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom; mem_err = 1'($urandom);
            end
            for (int i = 1; i <= vdly; i++) begin
                chk("mem_valid_wait", mem_valid, 0);
                chk("resp_valid_wait", resp_valid, 0);
                chk("req_ready_wait", req_ready, 0);
                if (i == vdly) begin mem_rvalid = 1'b1; mem_rdata = word; mem_err = merr; end
                tick();
                mem_rvalid = 1'b0; mem_rdata = $urandom; mem_err = 1'($urandom);
            end
            if (wen && !merr)
                for (int k = 0; k < 4; k++) if (exp_m[k]) mem[waddr][8*k +: 8] = exp_wd[8*k +: 8];
        end
        for (int i = 0; i <= pdly; i++) begin
            chk("resp_valid", resp_valid, 1);
            chk("resp_rdata", resp_rdata, exp_rd);
            chk("resp_err", resp_err, bad || merr);
            chk("req_ready_resp", req_ready, 0);
            chk("mem_valid_resp", mem_valid, 0);
            resp_ready = (i == pdly);
            tick();
        end
        resp_ready = 1'b0;
        chk("resp_valid_after", resp_valid, 0);
        chk("req_ready_after", req_ready, 1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_mem_valid", mem_valid, 0);
        chk("post_rst_mem_addr", mem_addr, 0);
        chk("post_rst_resp_valid", resp_valid, 0);
        chk("post_rst_resp_rdata", resp_rdata, 0);

        mem[32'h1000] = 32'h8000_0000;
        txn(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 0, 1'b0);
        txn(1'b0, 3'b100, 32'h1003, 32'h0, 0, 0, 0, 1'b0);
        txn(1'b1, 3'b001, 32'h2002, 32'h0000_BEEF, 0, 1, 0, 1'b0);
        txn(1'b0, 3'b010, 32'h3000, 32'h0, 3, 2, 0, 1'b0);
        txn(1'b0, 3'b101, 32'h2002, 32'h0, 1, 0, 4, 1'b0);
        txn(1'b0, 3'b011, 32'h3000, 32'h0, 0, 0, 0, 1'b0);
        txn(1'b1, 3'b100, 32'h3000, 32'h1234, 0, 0, 0, 1'b0);
        mem[32'h4000] = 32'hCAFE_F00D;
        txn(1'b0, 3'b010, 32'h4001, 32'h0, 0, 0, 0, 1'b0);
        txn(1'b0, 3'b001, 32'h4003, 32'h0, 0, 0, 0, 1'b0);
        txn(1'b0, 3'b010, 32'h4000, 32'h0, 2, 1, 1, 1'b1);

        mem[32'h5000] = 32'h1357_9BDF;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h5000;
        tick();
        req_valid = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("wait_mem_valid", mem_valid, 0);
        chk("wait_resp_valid", resp_valid, 0);
        rst = 1'b1;
        tick();
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_mem_valid", mem_valid, 0);
        chk("midrst_resp_valid", resp_valid, 0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_rvalid = 1'b0;
        chk("after_rst_req_ready", req_ready, 1);
        chk("after_rst_mem_valid", mem_valid, 0);
        chk("after_rst_resp_valid", resp_valid, 0);
        txn(1'b0, 3'b010, 32'h5000, 32'h0, 0, 0, 0, 1'b0);

        for (int n = 0; n < 200; n++)
            txn(1'($urandom), 3'($urandom_range(0, 7)), 32'h100 + $urandom_range(0, 31), $urandom,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 7) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
